// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_ctrl
//  Purpose  : Four-digit multiplexed display scan controller. Steps an active
//             digit index through 0..3, and holds the hex/point/blank data
//             the downstream decoder shows. New data is staged in a shadow
//             bank and committed only at frame boundaries, so a frame never
//             mixes old and new digits. An optional per-digit blink path
//             gates the blank outputs with a free-running blink phase.
//  Revision : 1.0  initial release
//
//  Parameters
//    CLK_DIV_W   : scan divider width; one digit step every 2^CLK_DIV_W clocks
//    BLINK_DIV_W : blink divider width; blink phase is the divider MSB
//
//  Configuration macro
//    SEG_BLINK_EN : when defined, the blink divider and the blink_mask path
//                   are built. When undefined, blink_mask is ignored and LES
//                   follows the committed blank bits only.
//
//  Ports
//    clk        in   system clock, all state on the rising edge
//    rst        in   asynchronous active-high reset
//    load       in   single-cycle strobe capturing the four data inputs
//    hex_in     in   [15:0] four hex digits, digit i = hex_in[4i+3:4i]
//    point_in   in   [3:0]  decimal point per digit, 1 = lit
//    blank_in   in   [3:0]  per-digit blank, 1 = dark
//    blink_mask in   [3:0]  per-digit blink enable, 1 = blink
//    scan       out  [1:0]  active digit index
//    HEXS       out  [15:0] committed hex digits
//    point      out  [3:0]  committed decimal points
//    LES        out  [3:0]  per-digit blank to the decoder, 1 = dark
//    frame_tick out  one-cycle pulse after each full four-digit frame
//    pending    out  captured data is waiting for the next frame boundary
// ============================================================================
module seg_scan_ctrl #(
   parameter int CLK_DIV_W   = 17,
   parameter int BLINK_DIV_W = 25
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [15:0] hex_in,
   input  logic [3:0]  point_in,
   input  logic [3:0]  blank_in,
   input  logic [3:0]  blink_mask,
   output logic [1:0]  scan,
   output logic [15:0] HEXS,
   output logic [3:0]  point,
   output logic [3:0]  LES,
   output logic        frame_tick,
   output logic        pending
);

   // Out of reset every digit is dark until real data has been committed.
   localparam logic [3:0] c_BLANK_RST = 4'hF;
   localparam logic [1:0] c_LAST_DIGIT = 2'd3;

   // ------------------------------------------------------------------------
   // Scan timing
   // ------------------------------------------------------------------------
   logic [CLK_DIV_W-1:0] scan_div_q;
   logic [1:0]           scan_q;
   logic                 frame_tick_q;
   logic                 scan_tick;
   logic                 frame_edge;

   // The divider wraps on its own; the step happens on the all-ones count.
   assign scan_tick  = &scan_div_q;
   assign frame_edge = scan_tick && (scan_q == c_LAST_DIGIT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scan_div_q   <= '0;
         scan_q       <= 2'd0;
         frame_tick_q <= 1'b0;
      end else begin
         scan_div_q   <= scan_div_q + 1'b1;
         frame_tick_q <= frame_edge;
         if (scan_tick) begin
            scan_q <= scan_q + 2'd1;   // 3 -> 0 wraps naturally in 2 bits
         end
      end
   end

   // ------------------------------------------------------------------------
   // Shadow / committed data banks
   // ------------------------------------------------------------------------
   logic [15:0] shd_hex_q,   shd_hex_d;
   logic [3:0]  shd_point_q, shd_point_d;
   logic [3:0]  shd_blank_q, shd_blank_d;
   logic [15:0] com_hex_q,   com_hex_d;
   logic [3:0]  com_point_q, com_point_d;
   logic [3:0]  com_blank_q, com_blank_d;
   logic        pending_q,   pending_d;
   logic [3:0]  les_q,       les_d;

`ifdef SEG_BLINK_EN
   logic [3:0]  shd_mask_q,  shd_mask_d;
   logic [3:0]  com_mask_q,  com_mask_d;
`else
   // The blink input has no function in this build.
   logic        unused_blink_mask;
   assign unused_blink_mask = ^blink_mask;
`endif

   always_comb begin
      shd_hex_d   = shd_hex_q;
      shd_point_d = shd_point_q;
      shd_blank_d = shd_blank_q;
      com_hex_d   = com_hex_q;
      com_point_d = com_point_q;
      com_blank_d = com_blank_q;
      pending_d   = pending_q;
`ifdef SEG_BLINK_EN
      shd_mask_d  = shd_mask_q;
      com_mask_d  = com_mask_q;
`endif

      if (frame_edge) begin
         // A load landing exactly on the boundary is the newest data, so it
         // bypasses the shadow bank and supersedes anything staged earlier.
         if (load) begin
            com_hex_d   = hex_in;
            com_point_d = point_in;
            com_blank_d = blank_in;
`ifdef SEG_BLINK_EN
            com_mask_d  = blink_mask;
`endif
         end else if (pending_q) begin
            com_hex_d   = shd_hex_q;
            com_point_d = shd_point_q;
            com_blank_d = shd_blank_q;
`ifdef SEG_BLINK_EN
            com_mask_d  = shd_mask_q;
`endif
         end
         pending_d = 1'b0;
      end else if (load) begin
         // Later loads in the same frame simply overwrite the shadow bank.
         shd_hex_d   = hex_in;
         shd_point_d = point_in;
         shd_blank_d = blank_in;
`ifdef SEG_BLINK_EN
         shd_mask_d  = blink_mask;
`endif
         pending_d   = 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // Blink phase and blank output
   // ------------------------------------------------------------------------
`ifdef SEG_BLINK_EN
   logic [BLINK_DIV_W-1:0] blink_div_q;
   logic                   blink_phase;

   assign blink_phase = blink_div_q[BLINK_DIV_W-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blink_div_q <= '0;
      end else begin
         blink_div_q <= blink_div_q + 1'b1;
      end
   end

   always_comb begin
      les_d = com_blank_q | (com_mask_q & {4{blink_phase}});
   end
`else
   always_comb begin
      les_d = com_blank_q;
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shd_hex_q   <= 16'h0000;
         shd_point_q <= 4'h0;
         shd_blank_q <= 4'h0;
         com_hex_q   <= 16'h0000;
         com_point_q <= 4'h0;
         com_blank_q <= c_BLANK_RST;
         pending_q   <= 1'b0;
         les_q       <= c_BLANK_RST;
`ifdef SEG_BLINK_EN
         shd_mask_q  <= 4'h0;
         com_mask_q  <= 4'h0;
`endif
      end else begin
         shd_hex_q   <= shd_hex_d;
         shd_point_q <= shd_point_d;
         shd_blank_q <= shd_blank_d;
         com_hex_q   <= com_hex_d;
         com_point_q <= com_point_d;
         com_blank_q <= com_blank_d;
         pending_q   <= pending_d;
         // LES is registered from the committed bank, so it trails a
         // commit or a blink phase change by one clock.
         les_q       <= les_d;
`ifdef SEG_BLINK_EN
         shd_mask_q  <= shd_mask_d;
         com_mask_q  <= com_mask_d;
`endif
      end
   end

   // ------------------------------------------------------------------------
   // Outputs: every one comes straight from a register.
   // ------------------------------------------------------------------------
   assign scan       = scan_q;
   assign HEXS       = com_hex_q;
   assign point      = com_point_q;
   assign LES        = les_q;
   assign frame_tick = frame_tick_q;
   assign pending    = pending_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg_scan_ctrl
//  Purpose  : Self-checking bench for seg_scan_ctrl (CLK_DIV_W=2,
//             BLINK_DIV_W=3). Stimulus pushes the expected frame contents
//             into a queue; a monitor pops one entry per frame_tick and
//             compares HEXS/point/pending in the tick cycle and LES one
//             cycle later (LES trails the commit by a clock).
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        load = 1'b0;
   logic [15:0] hex_in = 16'h0;
   logic [3:0]  point_in = 4'h0;
   logic [3:0]  blank_in = 4'h0;
   logic [3:0]  blink_mask = 4'h0;
   logic [1:0]  scan;
   logic [15:0] HEXS;
   logic [3:0]  point;
   logic [3:0]  LES;
   logic        frame_tick;
   logic        pending;

   int total = 0;
   int bad   = 0;
   bit seen_aaaa = 1'b0;

   typedef struct packed {
      logic [15:0] hex;
      logic [3:0]  pt;
      logic        pd;
      logic [3:0]  les;
   } exp_t;

   exp_t sb_q[$];

   seg_scan_ctrl #(.CLK_DIV_W(2), .BLINK_DIV_W(3)) dut (
      .clk(clk), .rst(rst), .load(load), .hex_in(hex_in),
      .point_in(point_in), .blank_in(blank_in), .blink_mask(blink_mask),
      .scan(scan), .HEXS(HEXS), .point(point), .LES(LES),
      .frame_tick(frame_tick), .pending(pending)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic exp_t mk(input logic [15:0] h, input logic [3:0] p,
                               input logic d, input logic [3:0] l);
      exp_t e;
      e.hex = h; e.pt = p; e.pd = d; e.les = l;
      return e;
   endfunction

   // Drive a one-cycle load from a negedge; returns at the following negedge.
   task automatic do_load(input logic [15:0] h, input logic [3:0] p,
                          input logic [3:0] b, input logic [3:0] m);
      hex_in = h; point_in = p; blank_in = b; blink_mask = m;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic wait_frame();
      bit got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (frame_tick === 1'b1) got = 1'b1;
      end
      chk("frame_timeout", {31'd0, got}, 32'd1);
   endtask

   // Scoreboard monitor
   initial begin
      logic [15:0] hx;
      logic [3:0]  pt;
      logic        pd;
      exp_t        e;
      forever begin
         @(negedge clk);
         if (frame_tick === 1'b1) begin
            hx = HEXS; pt = point; pd = pending;
            @(negedge clk);
            if (sb_q.size() == 0) begin
               chk("sb_underflow", 32'd0, 32'd1);
            end else begin
               e = sb_q.pop_front();
               chk("frame_HEXS",    {16'd0, hx},  {16'd0, e.hex});
               chk("frame_point",   {28'd0, pt},  {28'd0, e.pt});
               chk("frame_pending", {31'd0, pd},  {31'd0, e.pd});
               chk("frame_LES",     {28'd0, LES}, {28'd0, e.les});
            end
         end
      end
   end

   always @(negedge clk) if (HEXS === 16'hAAAA) seen_aaaa = 1'b1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic [3:0] les_exp;

      // Asynchronous reset without any clock edge
      #2 rst = 1'b1;
      #1;
      chk("rst_scan",       {30'd0, scan},       32'd0);
      chk("rst_HEXS",       {16'd0, HEXS},       32'd0);
      chk("rst_point",      {28'd0, point},      32'd0);
      chk("rst_LES",        {28'd0, LES},        32'hF);
      chk("rst_frame_tick", {31'd0, frame_tick}, 32'd0);
      chk("rst_pending",    {31'd0, pending},    32'd0);

      // Two idle frames after release
      sb_q.push_back(mk(16'h0000, 4'h0, 1'b0, 4'hF));
      sb_q.push_back(mk(16'h0000, 4'h0, 1'b0, 4'hF));
      repeat (2) @(negedge clk);
      rst = 1'b0;

      for (int k = 1; k <= 32; k++) begin
         @(negedge clk);
         chk("idle_scan",  {30'd0, scan},       (k / 4) % 4);
         chk("idle_ftick", {31'd0, frame_tick}, (k % 16 == 0) ? 32'd1 : 32'd0);
      end

      // Staged load while scan=1
      repeat (4) @(negedge clk);
      chk("load1_scan", {30'd0, scan}, 32'd1);
      sb_q.push_back(mk(16'h1234, 4'h2, 1'b0, 4'h0));
      do_load(16'h1234, 4'h2, 4'h0, 4'h0);
      chk("load1_pending", {31'd0, pending}, 32'd1);
      chk("load1_HEXS_held", {16'd0, HEXS}, 32'h0);
      wait_frame();

      // Two loads in one frame: last wins
      repeat (2) @(negedge clk);
      do_load(16'hAAAA, 4'h0, 4'h0, 4'h0);
      chk("multi_HEXS_held", {16'd0, HEXS}, 32'h1234);
      chk("multi_pending", {31'd0, pending}, 32'd1);
      repeat (3) @(negedge clk);
      sb_q.push_back(mk(16'h5555, 4'h0, 1'b0, 4'h0));
      do_load(16'h5555, 4'h0, 4'h0, 4'h0);
      wait_frame();

      // Load on the boundary edge itself
      repeat (15) @(negedge clk);
      chk("bnd_scan", {30'd0, scan}, 32'd3);
      chk("bnd_pending_before", {31'd0, pending}, 32'd0);
      sb_q.push_back(mk(16'hBEEF, 4'h9, 1'b0, 4'h5));
      do_load(16'hBEEF, 4'h9, 4'h5, 4'h0);
      chk("bnd_pending_after", {31'd0, pending}, 32'd0);
      chk("bnd_HEXS", {16'd0, HEXS}, 32'hBEEF);
      sb_q.push_back(mk(16'hBEEF, 4'h9, 1'b0, 4'h5));
      wait_frame();

      // Blink on digit 0
      repeat (2) @(negedge clk);
      sb_q.push_back(mk(16'h0000, 4'h0, 1'b0, 4'h0));
      do_load(16'h0000, 4'h0, 4'h0, 4'h1);
      sb_q.push_back(mk(16'h0000, 4'h0, 1'b0, 4'h0));
      wait_frame();
      for (int j = 1; j <= 16; j++) begin
         @(negedge clk);
`ifdef SEG_BLINK_EN
         les_exp = (((j - 1) % 8) >= 4) ? 4'h1 : 4'h0;
`else
         les_exp = 4'h0;
`endif
         chk("blink_LES", {28'd0, LES}, {28'd0, les_exp});
      end

      // Asynchronous reset mid-frame with data pending
      repeat (2) @(negedge clk);
      do_load(16'h7777, 4'h3, 4'h0, 4'h0);
      chk("prerst_pending", {31'd0, pending}, 32'd1);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_scan",    {30'd0, scan},    32'd0);
      chk("arst_HEXS",    {16'd0, HEXS},    32'd0);
      chk("arst_point",   {28'd0, point},   32'd0);
      chk("arst_LES",     {28'd0, LES},     32'hF);
      chk("arst_pending", {31'd0, pending}, 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      sb_q.push_back(mk(16'h0000, 4'h0, 1'b0, 4'hF));
      repeat (3) @(negedge clk);
      chk("restart_scan0", {30'd0, scan}, 32'd0);
      @(negedge clk);
      chk("restart_scan1", {30'd0, scan}, 32'd1);
      wait_frame();
      repeat (2) @(negedge clk);

      chk("sb_drained", sb_q.size(), 32'd0);
      chk("aaaa_never_shown", {31'd0, seen_aaaa}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV_W, default 17, giving scan-divider width; one digit step every 2^CLK_DIV_W clocks; legal range >= 1.
REQ-002 SHALL have parameter BLINK_DIV_W, default 25, giving blink-divider width; blink phase = divider MSB; legal range >= 1.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 load  input  1  single-cycle strobe; capture display data below.
REQ-006 hex_in  input  16  four hex digits, digit i = hex_in[4i+3:4i].
REQ-007 point_in  input  4  decimal point per digit, 1 = lit.
REQ-008 blank_in  input  4  per-digit blank, 1 = dark.
REQ-009 blink_mask  input  4  per-digit blink enable, 1 = blink.
REQ-010 scan  output  2  active digit index to downstream display decoder.
REQ-011 HEXS  output  16  committed hex digits to display decoder.
REQ-012 point  output  4  committed decimal points, 1 = lit.
REQ-013 LES  output  4  per-digit blank to display decoder, 1 = dark.
REQ-014 frame_tick  output  1  one-cycle pulse after each full 4-digit frame.
REQ-015 pending  output  1  1 = captured data waiting for frame boundary.

Function
REQ-016 Scan divider SHALL count clk modulo 2^CLK_DIV_W; scan_tick = divider at all-ones.
REQ-017 On scan_tick edge, scan SHALL increment, wrapping 3 -> 0.
REQ-018 Frame boundary = scan_tick edge with scan==3; frame_tick SHALL be 1 for exactly the cycle following that edge, else 0.
REQ-019 load=1 SHALL copy hex_in, point_in, blank_in, blink_mask into shadow registers and set pending=1.
REQ-020 At frame boundary with pending=1, shadow SHALL transfer to committed HEXS/point/blank/mask and pending SHALL clear on same edge.
REQ-021 load coinciding with frame boundary: SHALL write inputs directly to committed registers on that edge; pending=0 afterward.
REQ-022 Multiple loads before boundary: last load wins; earlier captures discarded.
REQ-023 Committed outputs SHALL change only at frame boundaries (no mid-frame tearing).
REQ-024 Blink divider SHALL free-run modulo 2^BLINK_DIV_W; blink_phase = its MSB.
REQ-025 LES[i] SHALL equal committed blank[i] OR (committed mask[i] AND blink_phase), registered (one-cycle latency from phase change).
REQ-026 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-027 rst=1 SHALL immediately, without clk, force: scan=0, HEXS=16'h0000, point=4'h0, LES=4'hF, frame_tick=0, pending=0, both dividers=0, shadow=0, committed mask=0.
REQ-028 Reset asserted mid-frame or with pending=1 SHALL discard pending data; operation resumes from scan=0 on first edge after release.

Configuration
REQ-029 Macro SEG_BLINK_EN defined: blink divider and blink_mask path present per REQ-024/025.
REQ-030 SEG_BLINK_EN undefined: blink divider omitted, blink_mask ignored, LES = committed blank only; all other behaviour identical.

Verification (CLK_DIV_W=2, BLINK_DIV_W=3)
REQ-031 Release reset, no load -> scan steps 0,1,2,3,0 every 4 clocks; frame_tick one pulse per 16 clocks; LES=4'hF, HEXS=0.
REQ-032 load hex_in=16'h1234, point_in=4'h2, blank_in=0 while scan=1 -> pending=1, HEXS stays 0 until boundary; then HEXS=16'h1234, point=4'h2, LES=4'h0, pending=0.
REQ-033 load 16'hAAAA then 16'h5555 within one frame -> after boundary HEXS=16'h5555; 16'hAAAA never appears.
REQ-034 load 16'hBEEF on boundary edge -> HEXS=16'hBEEF after that edge, pending never 1.
REQ-035 blank_in=0, blink_mask=4'h1 committed -> with SEG_BLINK_EN LES[0] toggles every 4 clocks, LES[3:1]=0; without macro LES=4'h0 constant.
REQ-036 Assert rst asynchronously mid-frame with pending=1 -> outputs reach reset values before next clk edge; pending=0; scan restarts at 0.
